// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction-ROM consumers.
// Holds the loader state encoding, instruction geometry and checksum helper.
package prog_loader_pkg;

    localparam int INSTR_W         = 24;
    localparam int BYTES_PER_INSTR = 3;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    // Running mod-256 payload checksum.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Counts idle cycles inside a frame; expired flags the last allowed idle cycle.
// A TIMEOUT of 0 disables expiry entirely.
module idle_timer #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] timer_r;

    // Idle-cycle counter, restarted by every transfer and outside frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (clear) begin
            timer_r <= '0;
        end else if (enable) begin
            timer_r <= timer_r + CNT_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    assign expired = (TIMEOUT > 0) && enable && (timer_r == LAST_CNT);

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream (SYNC, LEN, 3*LEN payload bytes, CHK) into program
// memory as 24-bit words while holding the CPU in reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter int         DEPTH   = 255,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_w_enable,
    output logic [ADDR_W-1:0]  mem_w_addr,
    output logic [INSTR_W-1:0] mem_w_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    localparam logic [7:0] DEPTH_B   = 8'(DEPTH);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

    state_t state_r, state_next_s;

    logic [INSTR_W-9:0] word_r;
    logic [7:0]         chk_r;
    logic [7:0]         len_r;
    logic [7:0]         word_cnt_r;
    logic [1:0]         byte_idx_r;

    logic               in_ready_r, mem_w_enable_r, cpu_hold_r, done_r, error_r;
    logic [ADDR_W-1:0]  mem_w_addr_r;
    logic [INSTR_W-1:0] mem_w_data_r;

    logic xfer_s, in_frame_s, last_byte_s, last_word_s, expired_s;
    logic cpu_hold_s, done_s, error_s, wr_s, start_s;

    assign xfer_s      = in_valid && in_ready_r;
    assign in_frame_s  = (state_r == LEN) || (state_r == PAYLOAD) || (state_r == CHECK);
    assign last_byte_s = (byte_idx_r == LAST_BYTE);
    assign last_word_s = (word_cnt_r == (len_r - 8'd1));

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (xfer_s || !in_frame_s),
        .enable  (in_frame_s && !xfer_s),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a transfer always wins over an expiring idle timer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (xfer_s && (in_data == SYNC)) state_next_s = LEN;
                else                              state_next_s = state_r;
            end
            LEN: begin
                if (xfer_s) begin
                    if ((in_data == 8'd0) || (in_data > DEPTH_B)) state_next_s = ERR;
                    else                                           state_next_s = PAYLOAD;
                end else if (expired_s) begin
                    state_next_s = ERR;
                end else begin
                    state_next_s = state_r;
                end
            end
            PAYLOAD: begin
                if (xfer_s) begin
                    if (last_byte_s && last_word_s) state_next_s = CHECK;
                    else                            state_next_s = state_r;
                end else if (expired_s) begin
                    state_next_s = ERR;
                end else begin
                    state_next_s = state_r;
                end
            end
            CHECK: begin
                if (xfer_s) begin
                    if (in_data == chk_r) state_next_s = DONE;
                    else                  state_next_s = ERR;
                end else if (expired_s) begin
                    state_next_s = ERR;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        cpu_hold_s = 1'b0;
        done_s     = 1'b0;
        error_s    = 1'b0;
        case (state_next_s)
            LEN, PAYLOAD, CHECK: cpu_hold_s = 1'b1;
            DONE:                done_s     = 1'b1;
            ERR:                 error_s    = 1'b1;
            default:             cpu_hold_s = 1'b0;
        endcase
        wr_s    = (state_r == PAYLOAD) && xfer_s && last_byte_s;
        start_s = !in_frame_s && (state_next_s == LEN);
    end

    // Datapath: word assembly, checksum, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r     <= 1'b0;
            mem_w_enable_r <= 1'b0;
            mem_w_addr_r   <= '0;
            mem_w_data_r   <= '0;
            cpu_hold_r     <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            word_r         <= '0;
            chk_r          <= 8'd0;
            len_r          <= 8'd0;
            word_cnt_r     <= 8'd0;
            byte_idx_r     <= 2'd0;
        end else begin
            in_ready_r     <= 1'b1;
            mem_w_enable_r <= wr_s;
            cpu_hold_r     <= cpu_hold_s;
            done_r         <= done_s;
            error_r        <= error_s;
            if (wr_s) begin
                mem_w_addr_r <= ADDR_W'(word_cnt_r);
                mem_w_data_r <= {word_r, in_data};
            end
            if (start_s) begin
                word_r     <= '0;
                chk_r      <= 8'd0;
                len_r      <= 8'd0;
                word_cnt_r <= 8'd0;
                byte_idx_r <= 2'd0;
            end else if ((state_r == LEN) && xfer_s) begin
                len_r <= in_data;
            end else if ((state_r == PAYLOAD) && xfer_s) begin
                word_r <= {word_r[INSTR_W-17:0], in_data};
                chk_r  <= chk_add(chk_r, in_data);
                if (last_byte_s) begin
                    byte_idx_r <= 2'd0;
                    word_cnt_r <= word_cnt_r + 8'd1;
                end else begin
                    byte_idx_r <= byte_idx_r + 2'd1;
                end
            end
        end
    end

    assign in_ready     = in_ready_r;
    // A strobe already registered is squashed while reset is asserted.
    assign mem_w_enable = mem_w_enable_r && !rst;
    assign mem_w_addr   = mem_w_addr_r;
    assign mem_w_data   = mem_w_data_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames from the test plan plus random frames,
// all checked against a frame-level model of the load protocol.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam logic [7:0] SYNC_B = 8'hA5;

    logic              clk, rst, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_w_enable, cpu_hold, done, error;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [23:0]       mem_w_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic        exp_done, exp_err;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC(SYNC_B), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_w_enable (mem_w_enable),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with a write strobe is logged as {addr, data}.
    always @(negedge clk) begin
        if (mem_w_enable) got_q.push_back({mem_w_addr, mem_w_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send1(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Frame-level reference: skip to the first SYNC, then apply LEN bounds,
    // big-endian word packing and the mod-256 payload sum.
    task automatic model_frame();
        int p, n, sum;
        logic [23:0] w;
        exp_q.delete();
        p = 0;
        while (p < frame_q.size() && frame_q[p] != SYNC_B) p++;
        n = int'(frame_q[p+1]);
        if (n == 0 || n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            sum = 0;
            for (int k = 0; k < n; k++) begin
                w = {frame_q[p+2+3*k], frame_q[p+3+3*k], frame_q[p+4+3*k]};
                sum = sum + int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
                exp_q.push_back({8'(k), w});
            end
            exp_done = ((sum % 256) == int'(frame_q[p+2+3*n]));
            exp_err  = !exp_done;
        end
    endtask

    task automatic compare_frame(input string tag);
        model_frame();
        check_val({tag, " nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val({tag, " wr"}, got_q[i], exp_q[i]);
        check_val({tag, " done"}, 32'(done), 32'(exp_done));
        check_val({tag, " error"}, 32'(error), 32'(exp_err));
        check_val({tag, " hold"}, 32'(cpu_hold), 32'd0);
    endtask

    task automatic run_frame(input string tag);
        got_q.delete();
        foreach (frame_q[i]) send1(frame_q[i]);
        repeat (3) @(negedge clk);
        compare_frame(tag);
    endtask

    initial begin
        logic [7:0] b, chk;
        int n, sum;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        check_val("rst in_ready", 32'(in_ready), 32'd0);
        check_val("rst wen", 32'(mem_w_enable), 32'd0);
        check_val("rst addr", 32'(mem_w_addr), 32'd0);
        check_val("rst data", 32'(mem_w_data), 32'd0);
        check_val("rst hold", 32'(cpu_hold), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst error", 32'(error), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("in_ready", 32'(in_ready), 32'd1);

        // Nominal frame, stepped to check hold window and write latency.
        // The payload sums to 0x165, so the matching CHK byte is 0x65.
        frame_q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
        got_q.delete();
        check_val("nom hold pre", 32'(cpu_hold), 32'd0);
        send1(8'hA5);
        check_val("nom hold sync", 32'(cpu_hold), 32'd1);
        send1(8'h02); send1(8'h11); send1(8'h22); send1(8'h33);
        check_val("nom wen0", 32'(mem_w_enable), 32'd1);
        check_val("nom w0", {mem_w_addr, mem_w_data}, {8'h00, 24'h112233});
        send1(8'h44);
        check_val("nom wen pulse", 32'(mem_w_enable), 32'd0);
        send1(8'h55); send1(8'h66);
        check_val("nom w1", {mem_w_addr, mem_w_data}, {8'h01, 24'h445566});
        check_val("nom hold chk", 32'(cpu_hold), 32'd1);
        send1(8'h65);
        check_val("nom hold post", 32'(cpu_hold), 32'd0);
        check_val("nom done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        compare_frame("nominal");

        frame_q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h66};
        run_frame("badchk");
        frame_q = {8'hA5, 8'h00};
        run_frame("len0");
        frame_q = {8'hA5, 8'h05};
        run_frame("len5");
        frame_q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h33,
                   8'h44, 8'h55, 8'h66, 8'h65};
        run_frame("garbage");

        // Stall 16 cycles after the 2nd payload byte: error on the 16th edge.
        got_q.delete();
        send1(8'hA5); send1(8'h02); send1(8'h11); send1(8'h22);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 15) check_val("to16 pre", 32'(error), 32'd0);
            if (i == 16) begin
                check_val("to16 error", 32'(error), 32'd1);
                check_val("to16 hold", 32'(cpu_hold), 32'd0);
            end
        end
        check_val("to16 nwr", 32'(got_q.size()), 32'd0);

        // Stall 15 cycles, then resume: the frame still completes.
        got_q.delete();
        send1(8'hA5); send1(8'h02); send1(8'h11); send1(8'h22);
        repeat (15) @(negedge clk);
        send1(8'h33); send1(8'h44); send1(8'h55); send1(8'h66); send1(8'h65);
        repeat (3) @(negedge clk);
        frame_q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
        compare_frame("to15");

        // Reset raised in the cycle after the 3rd byte of word 0.
        got_q.delete();
        send1(8'hA5); send1(8'h02); send1(8'h11); send1(8'h22);
        in_valid = 1'b1; in_data = 8'h33;
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check_val("mrst wen", 32'(mem_w_enable), 32'd0);
        @(negedge clk);
        check_val("mrst outs", {in_ready, mem_w_enable, cpu_hold, done, error}, 32'd0);
        check_val("mrst addr", 32'(mem_w_addr), 32'd0);
        check_val("mrst data", 32'(mem_w_data), 32'd0);
        check_val("mrst nwr", 32'(got_q.size()), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        frame_q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
        run_frame("after rst");

        // Random frames: optional garbage, any LEN in 0..DEPTH+1, some bad CHK.
        for (int f = 0; f < 30; f++) begin
            frame_q.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SYNC_B) b = 8'h00;
                frame_q.push_back(b);
            end
            frame_q.push_back(SYNC_B);
            n = int'($urandom_range(0, DEPTH + 1));
            frame_q.push_back(8'(n));
            if (n >= 1 && n <= DEPTH) begin
                sum = 0;
                repeat (3 * n) begin
                    b = 8'($urandom);
                    frame_q.push_back(b);
                    sum = sum + int'(b);
                end
                chk = 8'(sum);
                if ($urandom_range(0, 3) == 0) chk = chk + 8'd1;
                frame_q.push_back(chk);
            end
            run_frame("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
